// File: rtl/ex_operand_stage.sv
// ID/EX pipeline register with EX/MEM and MEM/WB operand forwarding, load-use bubble insertion,
// valid/ready stall and flush, feeding the ALU its final A/B operands and registered controls.
module ex_operand_stage #(
   parameter int unsigned XLEN = 64,
   parameter int unsigned RA_W = 5
) (
   input  logic            i_clk,
   input  logic            i_rst_n,
   input  logic            i_flush,
   // decode side
   input  logic            i_in_valid,
   output logic            o_in_ready,
   input  logic [RA_W-1:0] i_in_rs1,
   input  logic [RA_W-1:0] i_in_rs2,
   input  logic [RA_W-1:0] i_in_rd,
   input  logic [XLEN-1:0] i_in_rs1_data,
   input  logic [XLEN-1:0] i_in_rs2_data,
   input  logic [XLEN-1:0] i_in_imm,
   input  logic [3:0]      i_in_alu_op,
   input  logic            i_in_use_imm,
   input  logic            i_in_reg_write,
   input  logic            i_in_mem_read,
   input  logic            i_in_mem_write,
   // forwarding sources
   input  logic            i_exmem_wen,
   input  logic [RA_W-1:0] i_exmem_rd,
   input  logic [XLEN-1:0] i_exmem_data,
   input  logic            i_memwb_wen,
   input  logic [RA_W-1:0] i_memwb_rd,
   input  logic [XLEN-1:0] i_memwb_data,
   // execute side
   output logic            o_out_valid,
   input  logic            i_out_ready,
   output logic [XLEN-1:0] o_a,
   output logic [XLEN-1:0] o_b,
   output logic [3:0]      o_alu_op,
   output logic [XLEN-1:0] o_store_data,
   output logic [RA_W-1:0] o_rd,
   output logic            o_reg_write,
   output logic            o_mem_read,
   output logic            o_mem_write
);

   logic            r_valid;
   logic [RA_W-1:0] r_rs1_addr;
   logic [RA_W-1:0] r_rs2_addr;
   logic [RA_W-1:0] r_rd;
   logic [XLEN-1:0] r_rs1;
   logic [XLEN-1:0] r_rs2;
   logic [XLEN-1:0] r_imm;
   logic [3:0]      r_alu_op;
   logic            r_use_imm;
   logic            r_reg_write;
   logic            r_mem_read;
   logic            r_mem_write;

   logic            w_load_use;
   logic            w_advance;
   logic            w_in_ready;
   logic [XLEN-1:0] w_in_rs1_fwd;
   logic [XLEN-1:0] w_in_rs2_fwd;
   logic [XLEN-1:0] w_hold_rs1_fwd;
   logic [XLEN-1:0] w_hold_rs2_fwd;

   // EX/MEM beats MEM/WB; x0 is hard-wired and never forwarded.
   function automatic logic [XLEN-1:0] fwd(
      input logic [XLEN-1:0] x,
      input logic [RA_W-1:0] addr,
      input logic            exmem_wen,
      input logic [RA_W-1:0] exmem_rd,
      input logic [XLEN-1:0] exmem_data,
      input logic            memwb_wen,
      input logic [RA_W-1:0] memwb_rd,
      input logic [XLEN-1:0] memwb_data
   );
      logic [XLEN-1:0] res;
      res = x;
      if (addr != '0 && exmem_wen && exmem_rd == addr) begin
         res = exmem_data;
      end else if (addr != '0 && memwb_wen && memwb_rd == addr) begin
         res = memwb_data;
      end
      return res;
   endfunction

   assign w_in_rs1_fwd   = fwd(i_in_rs1_data, i_in_rs1, i_exmem_wen, i_exmem_rd, i_exmem_data,
                               i_memwb_wen, i_memwb_rd, i_memwb_data);
   assign w_in_rs2_fwd   = fwd(i_in_rs2_data, i_in_rs2, i_exmem_wen, i_exmem_rd, i_exmem_data,
                               i_memwb_wen, i_memwb_rd, i_memwb_data);
   assign w_hold_rs1_fwd = fwd(r_rs1, r_rs1_addr, i_exmem_wen, i_exmem_rd, i_exmem_data,
                               i_memwb_wen, i_memwb_rd, i_memwb_data);
   assign w_hold_rs2_fwd = fwd(r_rs2, r_rs2_addr, i_exmem_wen, i_exmem_rd, i_exmem_data,
                               i_memwb_wen, i_memwb_rd, i_memwb_data);

   // A held load whose rd is consumed by the incoming instruction cannot be forwarded in time.
   assign w_load_use = r_valid & r_mem_read & (r_rd != '0) & i_in_valid &
                       ((i_in_rs1 == r_rd) |
                        ((i_in_rs2 == r_rd) & ~i_in_use_imm) |
                        ((i_in_rs2 == r_rd) & i_in_mem_write));

   assign w_advance  = ~r_valid | i_out_ready;
   assign w_in_ready = w_advance & ~w_load_use & ~i_flush;
   assign o_in_ready = w_in_ready;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_valid     <= 1'b0;
         r_rs1_addr  <= '0;
         r_rs2_addr  <= '0;
         r_rd        <= '0;
         r_rs1       <= '0;
         r_rs2       <= '0;
         r_imm       <= '0;
         r_alu_op    <= '0;
         r_use_imm   <= 1'b0;
         r_reg_write <= 1'b0;
         r_mem_read  <= 1'b0;
         r_mem_write <= 1'b0;
      end else if (i_flush) begin
         r_valid <= 1'b0;
      end else if (w_advance) begin
         r_valid     <= i_in_valid & w_in_ready;
         r_rs1_addr  <= i_in_rs1;
         r_rs2_addr  <= i_in_rs2;
         r_rd        <= i_in_rd;
         r_rs1       <= w_in_rs1_fwd;
         r_rs2       <= w_in_rs2_fwd;
         r_imm       <= i_in_imm;
         r_alu_op    <= i_in_alu_op;
         r_use_imm   <= i_in_use_imm;
         r_reg_write <= i_in_reg_write;
         r_mem_read  <= i_in_mem_read;
         r_mem_write <= i_in_mem_write;
      end else begin
         // Stalled: keep refreshing operands so a producer retiring mid-stall is not lost.
         r_rs1 <= w_hold_rs1_fwd;
         r_rs2 <= w_hold_rs2_fwd;
      end
   end

   assign o_out_valid  = r_valid;
   assign o_a          = w_hold_rs1_fwd;
   assign o_store_data = w_hold_rs2_fwd;
   assign o_b          = r_use_imm ? r_imm : w_hold_rs2_fwd;
   assign o_alu_op     = r_alu_op;
   assign o_rd         = r_rd;
   assign o_reg_write  = r_reg_write & r_valid;
   assign o_mem_read   = r_mem_read & r_valid;
   assign o_mem_write  = r_mem_write & r_valid;

endmodule

// File: tb/tb_ex_operand_stage.sv
// Bench for ex_operand_stage: directed hazard scenarios followed by random traffic, all checked
// against a reference model of the held instruction and its forwarded operands.
module tb_ex_operand_stage;

   logic        clk;
   logic        rst_n;
   logic        flush;
   logic        in_valid;
   logic        in_ready;
   logic [4:0]  in_rs1, in_rs2, in_rd;
   logic [63:0] in_rs1_data, in_rs2_data, in_imm;
   logic [3:0]  in_alu_op;
   logic        in_use_imm, in_reg_write, in_mem_read, in_mem_write;
   logic        exmem_wen, memwb_wen;
   logic [4:0]  exmem_rd, memwb_rd;
   logic [63:0] exmem_data, memwb_data;
   logic        out_valid, out_ready;
   logic [63:0] a, b, store_data;
   logic [3:0]  alu_op;
   logic [4:0]  rd;
   logic        reg_write, mem_read, mem_write;

   int total = 0;
   int bad   = 0;

   ex_operand_stage #(.XLEN(64), .RA_W(5)) dut (
      .i_clk(clk), .i_rst_n(rst_n), .i_flush(flush),
      .i_in_valid(in_valid), .o_in_ready(in_ready),
      .i_in_rs1(in_rs1), .i_in_rs2(in_rs2), .i_in_rd(in_rd),
      .i_in_rs1_data(in_rs1_data), .i_in_rs2_data(in_rs2_data), .i_in_imm(in_imm),
      .i_in_alu_op(in_alu_op), .i_in_use_imm(in_use_imm), .i_in_reg_write(in_reg_write),
      .i_in_mem_read(in_mem_read), .i_in_mem_write(in_mem_write),
      .i_exmem_wen(exmem_wen), .i_exmem_rd(exmem_rd), .i_exmem_data(exmem_data),
      .i_memwb_wen(memwb_wen), .i_memwb_rd(memwb_rd), .i_memwb_data(memwb_data),
      .o_out_valid(out_valid), .i_out_ready(out_ready),
      .o_a(a), .o_b(b), .o_alu_op(alu_op), .o_store_data(store_data), .o_rd(rd),
      .o_reg_write(reg_write), .o_mem_read(mem_read), .o_mem_write(mem_write)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference: the instruction the stage is architecturally holding.
   typedef struct {
      bit          v;
      bit [4:0]    rs1a, rs2a, rd;
      bit [63:0]   rs1, rs2, imm;
      bit [3:0]    op;
      bit          ui, rw, mr, mw;
   } instr_t;
   instr_t m;

   function automatic bit [63:0] bypass(bit [63:0] x, bit [4:0] addr);
      if (addr == 0) return x;
      if (exmem_wen && exmem_rd == addr) return exmem_data;
      if (memwb_wen && memwb_rd == addr) return memwb_data;
      return x;
   endfunction

   function automatic bit m_ready();
      bit hazard;
      hazard = m.v && m.mr && m.rd != 0 && in_valid &&
               (in_rs1 == m.rd || (in_rs2 == m.rd && (!in_use_imm || in_mem_write)));
      return (!m.v || out_ready) && !hazard && !flush;
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp)
      else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic chk_model();
      bit [63:0] sd;
      sd = bypass(m.rs2, m.rs2a);
      chk("in_ready",   {63'd0, in_ready},   {63'd0, m_ready()});
      chk("out_valid",  {63'd0, out_valid},  {63'd0, m.v});
      chk("A",          a,                   bypass(m.rs1, m.rs1a));
      chk("store_data", store_data,          sd);
      chk("B",          b,                   m.ui ? m.imm : sd);
      chk("alu_op",     {60'd0, alu_op},     {60'd0, m.op});
      chk("rd",         {59'd0, rd},         {59'd0, m.rd});
      chk("reg_write",  {63'd0, reg_write},  {63'd0, m.rw & m.v});
      chk("mem_read",   {63'd0, mem_read},   {63'd0, m.mr & m.v});
      chk("mem_write",  {63'd0, mem_write},  {63'd0, m.mw & m.v});
   endtask

   // Check current outputs, clock once, update the model, return at the next falling edge.
   task automatic cycle();
      instr_t nx;
      bit     rdy;
      #1;
      chk_model();
      nx  = m;
      rdy = m_ready();
      if (flush) begin
         nx.v = 0;
      end else if (!m.v || out_ready) begin
         nx.v    = in_valid && rdy;
         nx.rs1a = in_rs1;  nx.rs2a = in_rs2;  nx.rd = in_rd;
         nx.rs1  = bypass(in_rs1_data, in_rs1);
         nx.rs2  = bypass(in_rs2_data, in_rs2);
         nx.imm  = in_imm;  nx.op = in_alu_op;  nx.ui = in_use_imm;
         nx.rw   = in_reg_write;  nx.mr = in_mem_read;  nx.mw = in_mem_write;
      end else begin
         nx.rs1 = bypass(m.rs1, m.rs1a);
         nx.rs2 = bypass(m.rs2, m.rs2a);
      end
      @(posedge clk);
      m = nx;
      @(negedge clk);
   endtask

   task automatic idle_inputs();
      flush = 0; in_valid = 0; in_rs1 = 0; in_rs2 = 0; in_rd = 0;
      in_rs1_data = 0; in_rs2_data = 0; in_imm = 0; in_alu_op = 0;
      in_use_imm = 0; in_reg_write = 0; in_mem_read = 0; in_mem_write = 0;
      exmem_wen = 0; exmem_rd = 0; exmem_data = 0;
      memwb_wen = 0; memwb_rd = 0; memwb_data = 0;
      out_ready = 1;
   endtask

   task automatic issue(input bit [4:0] r1, input bit [4:0] r2, input bit [4:0] d,
                        input bit [63:0] d1, input bit [63:0] d2, input bit [3:0] op,
                        input bit rw, input bit mr, input bit mw);
      in_valid = 1; in_rs1 = r1; in_rs2 = r2; in_rd = d;
      in_rs1_data = d1; in_rs2_data = d2; in_alu_op = op; in_use_imm = 0;
      in_reg_write = rw; in_mem_read = mr; in_mem_write = mw;
   endtask

   task automatic clear_model();
      m = '{default: 0};
   endtask

   initial begin
      idle_inputs();
      clear_model();
      rst_n = 1;
      #2 rst_n = 0;
      #1;
      chk_model();
      chk("reset_A", a, 64'd0);
      @(negedge clk);
      rst_n = 1;

      // add x5,x1,x2 with x1=3, x2=4
      issue(5'd1, 5'd2, 5'd5, 64'd3, 64'd4, 4'd0, 1, 0, 0);
      cycle();
      idle_inputs();
      #1;
      chk("add_A", a, 64'd3);
      chk("add_B", b, 64'd4);
      chk("add_valid", {63'd0, out_valid}, 64'd1);
      cycle();

      // Both stages write x1: EX/MEM wins at capture and live
      issue(5'd1, 5'd0, 5'd8, 64'h99, 64'd0, 4'd2, 1, 0, 0);
      exmem_wen = 1; exmem_rd = 1; exmem_data = 64'h10;
      memwb_wen = 1; memwb_rd = 1; memwb_data = 64'h20;
      cycle();
      in_valid = 0;
      #1 chk("fwd_prio_A", a, 64'h10);
      // rs1 = x0 never forwarded
      issue(5'd0, 5'd0, 5'd9, 64'd0, 64'd0, 4'd0, 1, 0, 0);
      exmem_wen = 1; exmem_rd = 0; exmem_data = 64'h55;
      memwb_wen = 0;
      cycle();
      in_valid = 0;
      #1 chk("x0_A", a, 64'd0);
      idle_inputs();
      cycle();

      // ld x6 then add x7,x6,x1: exactly one bubble
      issue(5'd2, 5'd0, 5'd6, 64'd100, 64'd0, 4'd0, 1, 1, 0);
      in_use_imm = 1;
      cycle();
      issue(5'd6, 5'd1, 5'd7, 64'd0, 64'd1, 4'd0, 1, 0, 0);
      #1 chk("lu_stall_ready", {63'd0, in_ready}, 64'd0);
      cycle();
      #1 chk("lu_bubble_valid", {63'd0, out_valid}, 64'd0);
      chk("lu_bubble_rw", {63'd0, reg_write}, 64'd0);
      chk("lu_accept_ready", {63'd0, in_ready}, 64'd1);
      cycle();
      in_valid = 0;
      #1 chk("lu_add_valid", {63'd0, out_valid}, 64'd1);
      chk("lu_add_rd", {59'd0, rd}, 64'd7);
      cycle();

      // Forwarded 0xAB retires during a 3-cycle stall
      issue(5'd3, 5'd0, 5'd4, 64'd0, 64'd0, 4'd1, 1, 0, 0);
      exmem_wen = 1; exmem_rd = 3; exmem_data = 64'hAB;
      cycle();
      in_valid = 0; out_ready = 0;
      for (int i = 0; i < 3; i++) begin
         #1 chk("stall_A", a, 64'hAB);
         cycle();
         exmem_wen = 0; exmem_data = 64'h0;
      end
      out_ready = 1;
      #1 chk("handoff_A", a, 64'hAB);
      out_ready = 0;

      // Flush while holding and while decode presents
      issue(5'd1, 5'd2, 5'd11, 64'd5, 64'd6, 4'd3, 1, 0, 1);
      flush = 1;
      #1 chk("flush_ready", {63'd0, in_ready}, 64'd0);
      cycle();
      idle_inputs();
      #1 chk("flush_valid", {63'd0, out_valid}, 64'd0);
      chk("flush_rw", {63'd0, reg_write}, 64'd0);
      chk("flush_mw", {63'd0, mem_write}, 64'd0);
      cycle();

      // Random traffic with a small register window to provoke hazards
      for (int n = 0; n < 400; n++) begin
         flush        = ($urandom_range(0, 15) == 0);
         in_valid     = ($urandom_range(0, 3) != 0);
         out_ready    = ($urandom_range(0, 3) != 0);
         in_rs1       = 5'($urandom_range(0, 3));
         in_rs2       = 5'($urandom_range(0, 3));
         in_rd        = 5'($urandom_range(0, 3));
         in_rs1_data  = {$urandom, $urandom};
         in_rs2_data  = {$urandom, $urandom};
         in_imm       = {$urandom, $urandom};
         in_alu_op    = 4'($urandom);
         in_use_imm   = 1'($urandom);
         in_reg_write = 1'($urandom);
         in_mem_read  = 1'($urandom);
         in_mem_write = 1'($urandom);
         exmem_wen    = 1'($urandom);
         exmem_rd     = 5'($urandom_range(0, 3));
         exmem_data   = {$urandom, $urandom};
         memwb_wen    = 1'($urandom);
         memwb_rd     = 5'($urandom_range(0, 3));
         memwb_data   = {$urandom, $urandom};
         cycle();
      end

      // Asynchronous reset while an instruction is held and stalled
      idle_inputs();
      issue(5'd1, 5'd2, 5'd3, 64'd7, 64'd8, 4'd1, 1, 0, 1);
      cycle();
      in_valid = 0; out_ready = 0;
      #2 rst_n = 0;
      #1;
      clear_model();
      chk("async_valid", {63'd0, out_valid}, 64'd0);
      chk("async_A", a, 64'd0);
      chk("async_B", b, 64'd0);
      chk("async_ctrl", {61'd0, reg_write, mem_read, mem_write}, 64'd0);
      @(negedge clk);
      rst_n = 1;
      cycle();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
